// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 Hz raster constants, derived sync windows and the counter type
// used by the VGA sync controller and the tile/text datapath that consumes Qh/Qv.
package vga_timing_pkg;

   localparam int COUNT_W = 10;

   localparam int H_DISPLAY_DEF = 640;
   localparam int H_FRONT_DEF   = 16;
   localparam int H_SYNC_DEF    = 96;
   localparam int H_BACK_DEF    = 48;
   localparam int V_DISPLAY_DEF = 480;
   localparam int V_FRONT_DEF   = 10;
   localparam int V_SYNC_DEF    = 2;
   localparam int V_BACK_DEF    = 33;
   localparam int PRESCALE_DEF  = 4;

   localparam int H_TOTAL  = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
   localparam int V_TOTAL  = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;
   localparam int HS_START = H_DISPLAY_DEF + H_FRONT_DEF;
   localparam int HS_END   = HS_START + H_SYNC_DEF - 1;
   localparam int VS_START = V_DISPLAY_DEF + V_FRONT_DEF;
   localparam int VS_END   = VS_START + V_SYNC_DEF - 1;

   typedef logic [COUNT_W-1:0] count_t;

   // Inclusive window test shared by the hsync and vsync decoders.
   function automatic logic in_window(count_t value, count_t first, count_t last);
      return (value >= first) && (value <= last);
   endfunction

endpackage

// File: rtl/pixel_prescaler.sv
// Divides the system clock down to the pixel rate: pixel_tick is a registered one-cycle
// pulse per pixel, tick_due flags the cycle whose closing edge starts the next pixel.
module pixel_prescaler #(
   parameter int PRESCALE = 4
) (
   input  logic reloj,
   input  logic reset,
   output logic pixel_tick,
   output logic tick_due
);

   localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [CNT_W-1:0] prescaler;

   assign tick_due = (prescaler == CNT_LAST);

   // The counters downstream advance on the same edge that raises pixel_tick.
   always_ff @(posedge reloj) begin
      if (reset) begin
         prescaler  <= '0;
         pixel_tick <= 1'b0;
      end else begin
         prescaler  <= tick_due ? '0 : prescaler + CNT_ONE;
         pixel_tick <= tick_due;
      end
   end

endmodule

// File: rtl/vga_sync_controller.sv
// VGA raster timing: pixel/line counters Qh/Qv, active-low syncs, video_on and
// line/frame end pulses, all aligned to the same reloj edge.
module vga_sync_controller
   import vga_timing_pkg::*;
#(
   parameter int H_DISPLAY = H_DISPLAY_DEF,
   parameter int H_FRONT   = H_FRONT_DEF,
   parameter int H_SYNC    = H_SYNC_DEF,
   parameter int H_BACK    = H_BACK_DEF,
   parameter int V_DISPLAY = V_DISPLAY_DEF,
   parameter int V_FRONT   = V_FRONT_DEF,
   parameter int V_SYNC    = V_SYNC_DEF,
   parameter int V_BACK    = V_BACK_DEF,
   parameter int PRESCALE  = PRESCALE_DEF
) (
   input  logic               reloj,
   input  logic               reset,
   output logic [COUNT_W-1:0] Qh,
   output logic [COUNT_W-1:0] Qv,
   output logic               hsync,
   output logic               vsync,
   output logic               video_on,
   output logic               pixel_tick,
   output logic               fin_linea,
   output logic               fin_cuadro
);

   localparam count_t LINE_LAST  = count_t'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
   localparam count_t FRAME_LAST = count_t'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
   localparam count_t H_VISIBLE  = count_t'(H_DISPLAY);
   localparam count_t V_VISIBLE  = count_t'(V_DISPLAY);
   localparam count_t HS_FIRST   = count_t'(H_DISPLAY + H_FRONT);
   localparam count_t HS_LAST    = count_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
   localparam count_t VS_FIRST   = count_t'(V_DISPLAY + V_FRONT);
   localparam count_t VS_LAST    = count_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);
   localparam count_t ONE        = count_t'(1);

   logic   tick_due;
   count_t qh_next;
   count_t qv_next;
   logic   line_wrap;
   logic   frame_wrap;

   pixel_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .reloj      (reloj),
      .reset      (reset),
      .pixel_tick (pixel_tick),
      .tick_due   (tick_due)
   );

   // Next raster position; the syncs below decode this so they never lag Qh/Qv.
   always_comb begin
      qh_next    = Qh;
      qv_next    = Qv;
      line_wrap  = 1'b0;
      frame_wrap = 1'b0;
      if (tick_due) begin
         if (Qh == LINE_LAST) begin
            qh_next   = '0;
            line_wrap = 1'b1;
            if (Qv == FRAME_LAST) begin
               qv_next    = '0;
               frame_wrap = 1'b1;
            end else begin
               qv_next = Qv + ONE;
            end
         end else begin
            qh_next = Qh + ONE;
         end
      end
   end

   always_ff @(posedge reloj) begin
      if (reset) begin
         Qh         <= '0;
         Qv         <= '0;
         hsync      <= 1'b1;
         vsync      <= 1'b1;
         fin_linea  <= 1'b0;
         fin_cuadro <= 1'b0;
      end else begin
         Qh         <= qh_next;
         Qv         <= qv_next;
         hsync      <= !in_window(qh_next, HS_FIRST, HS_LAST);
         vsync      <= !in_window(qv_next, VS_FIRST, VS_LAST);
         fin_linea  <= line_wrap;
         fin_cuadro <= frame_wrap;
      end
   end

   assign video_on = (Qh < H_VISIBLE) && (Qv < V_VISIBLE) && !reset;

endmodule

// File: doc/vga_sync_controller.md
Name: vga_sync_controller

Overview:
- Generates the 640x480@60 Hz VGA raster timing that sequences the tile/text datapath (Posicion_Mosaicos).
- Drives the horizontal and vertical counters Qh/Qv (0..799, 0..524), the active-low hsync/vsync, video_on and the per-pixel enable.
- Runs from the 100 MHz system clock, divided down to a 25 MHz pixel rate (one pixel every 40 ns).
- Sits between the top level and the font/tile lookup, which consumes Qh/Qv and gates its pixel bit with video_on.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- PRESCALE, 4, system clocks per pixel; legal values are 1 or more

Ports:
- reloj  in  1  system clock, 100 MHz, rising edge
- reset  in  1  synchronous, active-high reset
- Qh  out  10  horizontal pixel counter, 0..H_TOTAL-1
- Qv  out  10  vertical line counter, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- video_on  out  1  high while (Qh,Qv) is inside the visible area
- pixel_tick  out  1  one-reloj pulse per pixel period
- fin_linea  out  1  one-reloj pulse on the tick where Qh wraps to 0
- fin_cuadro  out  1  one-reloj pulse on the tick where both Qh and Qv wrap to 0

Behaviour:
- Derived constants: H_TOTAL = sum of the H_ parameters (800); V_TOTAL = sum of the V_ parameters (525).
- Reset, sampled on the reloj edge: prescaler=0, Qh=0, Qv=0, hsync=1, vsync=1, pixel_tick=0, fin_linea=0, fin_cuadro=0. video_on is forced to 0 while reset is high.
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps.
  - pixel_tick is registered and is high for exactly one reloj cycle when the prescaler equals PRESCALE-1.
  - With PRESCALE=1, pixel_tick is constantly 1 after the first post-reset cycle.
- Horizontal counter: on the reloj edge where pixel_tick=1, Qh <= (Qh==H_TOTAL-1) ? 0 : Qh+1. Otherwise Qh holds.
- Vertical counter: advances only on the tick where Qh wraps. Qv <= (Qv==V_TOTAL-1) ? 0 : Qv+1.
- Sync outputs:
  - Registered, computed from the next-state counter values so they change on the same edge as Qh/Qv (zero skew).
  - hsync = 0 iff Qh is in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1], i.e. 656..751.
  - vsync = 0 iff Qv is in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1], i.e. 490..491.
- video_on: combinational, (Qh<H_DISPLAY) && (Qv<V_DISPLAY) && !reset.
- Line and frame pulses:
  - fin_linea is registered and high for one cycle coincident with Qh becoming 0.
  - fin_cuadro is high only when Qv also becomes 0; on that cycle fin_linea is also high.
- Latency:
  - First pixel_tick occurs PRESCALE reloj cycles after reset deasserts.
  - First Qh increment lands on that same edge.
- Reset asserted mid-frame: all state returns to reset values on the next edge, with no partial-line completion. Timing restarts from (0,0) after deassert.
- Widths and overflow: counters are 10 bits wide; H_TOTAL and V_TOTAL must be 1024 or less. Counters never exceed TOTAL-1, and no intermediate overflow is permitted.

Decomposition:
- Package vga_timing_pkg holds:
  - the 640x480 default constants;
  - the derived H_TOTAL, V_TOTAL, HS_START, HS_END, VS_START, VS_END;
  - a 10-bit counter typedef.
- One sub-module, pixel_prescaler (parameter PRESCALE; ports reloj, reset, pixel_tick), produces the pixel enable.
- The counters and sync decode remain in vga_sync_controller.

Test Plan:
- Reset: hold reset for 3 cycles, then release.
  -> Qh=0, Qv=0, hsync=1, vsync=1, video_on=0 during reset.
  -> First pixel_tick appears 4 cycles after release, with Qh=1 on that edge.
- Pixel cadence: run 100 reloj cycles.
  -> Exactly 25 pixel_tick pulses, each 1 cycle wide, spaced 4 cycles apart.
  -> Qh=25.
- Horizontal line: run one full line.
  -> hsync falls exactly when Qh becomes 656 and rises when Qh becomes 752.
  -> video_on falls at Qh=640.
  -> fin_linea pulses once when Qh goes 799->0, and Qv becomes 1 on the same edge.
- Frame wrap: run 800*525*4 cycles.
  -> vsync is low only for Qv=490..491.
  -> Qv goes 524->0 with fin_cuadro=1 and fin_linea=1 on the same cycle; this happens exactly once.
- Mid-frame reset: assert reset at Qh=300, Qv=200 for 1 cycle.
  -> Next edge shows Qh=0, Qv=0, hsync=1, vsync=1, no fin_linea pulse.
  -> Timing restarts identically to the cold-reset case.
- Prescale parameter: PRESCALE=1 instance.
  -> Qh increments every reloj cycle.
  -> A full line takes 800 cycles, with hsync low for exactly 96 cycles.
